thee_rc_seq: RTL and testbench

- Digital sequencer for the real-valued RC cell (vin/vcap) in thee; measures RC charge time.
- Per measurement: discharges the cap and waits for it to settle low, then drives vin to VDD and counts clock cycles until an external comparator reports vcap above threshold.
- Result goes to software/bench as a cycle count; a timeout guards against stuck or broken RC/comparator.
- Sits between the control bench/CSR layer and the RC model plus its threshold comparators.

---
 rtl/thee_pkg.sv | 22 ++
 rtl/thee_sat_cnt.sv | 38 +++
 rtl/thee_rc_seq.sv | 177 +++++++++++++++++
 tb/tb_thee_rc_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thee_pkg.sv
// Shared types and defaults for the thee RC charge-time sequencer.
package thee_pkg;

    localparam int  THEE_CNT_W_DEFAULT      = 16;
    localparam int  THEE_MAX_CYCLES_DEFAULT = 4000;
    localparam int  THEE_SETTLE_DEFAULT     = 4;
    localparam real THEE_VDD_DEFAULT        = 1.0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DISCH  = 3'd1,
        ST_CHARGE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } rc_seq_state_e;

    // vin is driven to VDD only while the cap is being charged
    function automatic logic drives_vdd(input rc_seq_state_e s);
        return (s == ST_CHARGE) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/thee_sat_cnt.sv
// Saturating up-counter with synchronous clear, enable and limit flags.
// 'reach' is high in the cycle whose increment will land on the limit,
// 'at_limit' while the stored value equals the limit (counter then holds).
module thee_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit,
    output logic             reach
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    assign cnt      = cnt_r;
    assign at_limit = (cnt_r == limit);
    assign reach    = en && !clr && !at_limit && (cnt_r == (limit - ONE));

    // counter register: clear wins, then saturating increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !at_limit) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/thee_rc_seq.sv
// RC charge-time sequencer: discharge until the low comparator is stable,
// then drive vin to VDD and count cycles until the high comparator trips.
// All outputs are registered; they are decoded from the next state so they
// line up with the state they describe.
module thee_rc_seq
    import thee_pkg::*;
#(
    parameter int  CNT_W      = THEE_CNT_W_DEFAULT,
    parameter int  MAX_CYCLES = THEE_MAX_CYCLES_DEFAULT,
    parameter int  SETTLE     = THEE_SETTLE_DEFAULT,
    parameter real VDD        = THEE_VDD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_hi,
    input  logic             cmp_lo,
    output real              vin_drv,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] count
);

    // elaboration-time parameter sanity
    if (MAX_CYCLES < 1) begin : g_bad_max_low
        $fatal(1, "thee_rc_seq: MAX_CYCLES must be >= 1");
    end
    if ((CNT_W < 31) && (MAX_CYCLES >= (1 << CNT_W))) begin : g_bad_max_high
        $fatal(1, "thee_rc_seq: MAX_CYCLES must be < 2**CNT_W");
    end
    if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
        $fatal(1, "thee_rc_seq: SETTLE must be in 1..15");
    end

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE);

    rc_seq_state_e    state_r;
    rc_seq_state_e    state_next;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next;
    logic             busy_r;
    logic             done_r;
    logic             timeout_r;
    logic             vdd_on_r;

    logic             in_disch_s;
    logic             settle_clr_s;
    logic [CNT_W-1:0] settle_cnt_s;
    logic             settle_full_s;
    logic             settle_reach_s;
    logic [CNT_W-1:0] phase_cnt_s;
    logic             phase_full_s;
    logic             phase_reach_s;

    assign in_disch_s   = (state_r == ST_DISCH);
    // any cycle with the cap not seen low restarts the settle window
    assign settle_clr_s = !in_disch_s || !cmp_lo;

    // consecutive cmp_lo cycles during discharge
    thee_sat_cnt #(.CNT_W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (settle_clr_s),
        .en       (cmp_lo),
        .limit    (SETTLE_L),
        .cnt      (settle_cnt_s),
        .at_limit (settle_full_s),
        .reach    (settle_reach_s)
    );

    // cycles spent in discharge, guards against a stuck low comparator
    thee_sat_cnt #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_disch_s),
        .en       (1'b1),
        .limit    (MAX_L),
        .cnt      (phase_cnt_s),
        .at_limit (phase_full_s),
        .reach    (phase_reach_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // next-state and charge-count update
    always_comb begin
        state_next = state_r;
        count_next = count_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_DISCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DISCH: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (settle_reach_s || settle_full_s) begin
                    // settling has priority if both finish on the same cycle
                    state_next = ST_CHARGE;
                    count_next = '0;
                end else if (phase_reach_s || phase_full_s) begin
                    state_next = ST_ERR;
                end else begin
                    state_next = ST_DISCH;
                end
            end
            ST_CHARGE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cmp_hi) begin
                    // threshold crossed: this cycle is not counted
                    state_next = ST_DONE;
                end else if (count_r >= (MAX_L - ONE)) begin
                    state_next = ST_ERR;
                    count_next = MAX_L;
                end else begin
                    state_next = ST_CHARGE;
                    count_next = count_r + ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // charge-count register, held between measurements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_next;
        end
    end

    // registered status outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            vdd_on_r  <= 1'b0;
        end else begin
            busy_r    <= (state_next != ST_IDLE);
            done_r    <= (state_next == ST_DONE);
            timeout_r <= (state_next == ST_ERR);
            vdd_on_r  <= drives_vdd(state_next);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign timeout = timeout_r;
    assign count   = count_r;
    assign vin_drv = vdd_on_r ? VDD : 0.0;

endmodule

// File: tb/tb_thee_rc_seq.sv
// Self-checking bench for thee_rc_seq: scripted comparator vectors, corner
// sequences (abort, reset mid-charge) and a simple discrete RC cell model.
module tb_thee_rc_seq;

    localparam int  CNT_W  = 16;
    localparam int  MAXC   = 600;
    localparam int  SETTLE = 4;
    localparam real VDD    = 1.0;
    localparam int  NVEC   = 8;

    typedef struct {
        int lo_at;     // cmp_lo is 1 for cycles c > lo_at
        int glitch;    // cycle where cmp_lo is forced 0 (0 = none)
        int hi_at;     // cmp_hi is 1 for cycles c > hi_at
        int exp_end;   // cycle index of the done/timeout pulse
        int exp_count;
        bit exp_done;
        bit exp_to;
        bit exp_vdd;   // vin_drv seen at VDD during the run
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             cmp_hi;
    logic             cmp_lo;
    real              vin_drv;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] count;

    logic lo_scr, hi_scr, lo_rc, hi_rc, rc_mode;
    logic rc_load;
    real  load_val;
    real  vcap;
    real  v0;
    logic prev_vdd;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [NVEC];

    assign cmp_lo = rc_mode ? lo_rc : lo_scr;
    assign cmp_hi = rc_mode ? hi_rc : hi_scr;

    thee_rc_seq #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAXC),
        .SETTLE     (SETTLE),
        .VDD        (VDD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cmp_hi  (cmp_hi),
        .cmp_lo  (cmp_lo),
        .vin_drv (vin_drv),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .count   (count)
    );

    always #5 clk = ~clk;

    // RC cell: R=1k, C=1nF, 10 ns step -> 1 % of the gap per cycle
    always @(negedge clk) begin
        if (rc_load) begin
            vcap     = load_val;
            prev_vdd = 1'b0;
        end else begin
            if ((vin_drv == VDD) && !prev_vdd) v0 = vcap;
            prev_vdd = (vin_drv == VDD);
            vcap     = vcap + (vin_drv - vcap) * 0.01;
        end
        lo_rc = (vcap <= 0.01);
        hi_rc = (vcap >= 0.632);
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_real(input string nm, input real act, input real exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %f expected %f", nm, act, exp_v);
        end
    endtask

    // expected count from the RC model given the cap voltage at charge start
    function automatic int rc_expect(input real vstart);
        real v = vstart;
        for (int k = 1; k < 10000; k++) begin
            v = v + (1.0 - v) * 0.01;
            if (v >= 0.632) return k - 1;
        end
        return -1;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int c = 1;
        bit ended = 1'b0;
        bit saw_vdd = 1'b0;
        int end_c = -1;
        bit got_done = 1'b0;
        bit got_to = 1'b0;
        int got_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        lo_scr = 1'b0;
        hi_scr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, int'(busy), 1);
        while (!ended && c <= 2000) begin
            if (vin_drv == VDD) saw_vdd = 1'b1;
            if (done || timeout) begin
                ended    = 1'b1;
                end_c    = c - 1;
                got_done = done;
                got_to   = timeout;
                got_cnt  = int'(count);
            end else begin
                lo_scr = (c > v.lo_at) && (c != v.glitch);
                hi_scr = (c > v.hi_at);
                @(negedge clk);
                c++;
            end
        end
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_wait: no done/timeout within 2000 cycles", nm);
        end else begin
            chk({nm, "_end"},   end_c,         v.exp_end);
            chk({nm, "_done"},  int'(got_done), int'(v.exp_done));
            chk({nm, "_to"},    int'(got_to),   int'(v.exp_to));
            chk({nm, "_count"}, got_cnt,        v.exp_count);
            chk({nm, "_vdd"},   int'(saw_vdd),  int'(v.exp_vdd));
        end
        @(negedge clk);
        chk({nm, "_idle_busy"}, int'(busy), 0);
        chk({nm, "_idle_pulse"}, int'(done | timeout), 0);
        chk_real({nm, "_idle_vin"}, vin_drv, 0.0);
    endtask

    task automatic run_rc(input real pre, input string nm);
        int n = 0;
        int first_vdd = -1;
        bit ended = 1'b0;
        @(negedge clk);
        #1;
        load_val = pre;
        rc_load  = 1'b1;
        rc_mode  = 1'b1;
        @(negedge clk);
        #1;
        rc_load = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!ended && n < 3000) begin
            if ((vin_drv == VDD) && (first_vdd < 0)) first_vdd = n;
            if (done || timeout) begin
                ended = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_wait: no done/timeout within 3000 cycles", nm);
        end else begin
            chk({nm, "_done"},  int'(done),    1);
            chk({nm, "_to"},    int'(timeout), 0);
            chk({nm, "_count"}, int'(count),   rc_expect(v0));
            chk({nm, "_v0low"}, int'(v0 <= 0.01), 1);
            if (pre == 0.0) chk({nm, "_latency"}, first_vdd, 1 + SETTLE - 1);
            else            chk({nm, "_disch_long"}, int'(first_vdd > SETTLE), 1);
        end
        @(negedge clk);
        chk_real({nm, "_vin_after"}, vin_drv, 0.0);
        rc_mode = 1'b0;
    endtask

    initial begin
        //           lo_at   gl  hi_at   end  count done to vdd
        vecs[0] = '{0,      0,  14,     15,  10,   1'b1, 1'b0, 1'b1};
        vecs[1] = '{0,      0,  0,      5,   0,    1'b1, 1'b0, 1'b1};
        vecs[2] = '{5,      0,  30,     31,  21,   1'b1, 1'b0, 1'b1};
        vecs[3] = '{0,      3,  20,     21,  13,   1'b1, 1'b0, 1'b1};
        vecs[4] = '{0,      0,  603,    604, 599,  1'b1, 1'b0, 1'b1};
        vecs[5] = '{0,      0,  100000, 604, 600,  1'b0, 1'b1, 1'b1};
        vecs[6] = '{100000, 0,  100000, 600, 600,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{596,    0,  600,    601, 0,    1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        lo_scr   = 1'b0;
        hi_scr   = 1'b0;
        rc_mode  = 1'b0;
        rc_load  = 1'b1;
        load_val = 0.0;
        vcap     = 0.0;
        v0       = 0.0;
        prev_vdd = 1'b0;

        // reset state
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_to", int'(timeout), 0);
        chk("rst_count", int'(count), 0);
        chk_real("rst_vin", vin_drv, 0.0);
        @(negedge clk);
        rst_n   = 1'b1;
        rc_load = 1'b0;

        // start and abort together: stay idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy0", int'(busy), 0);
        @(negedge clk);
        chk("sa_busy1", int'(busy), 0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // abort after 30 counted charge cycles
        @(negedge clk);
        start  = 1'b1;
        lo_scr = 1'b1;
        hi_scr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 30) @(negedge clk);
        chk("ab_pre_count", int'(count), 30);
        chk_real("ab_pre_vin", vin_drv, VDD);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk_real("ab_vin", vin_drv, 0.0);
        chk("ab_count", int'(count), 30);
        begin
            int pulses = int'(done | timeout);
            repeat (3) begin
                @(negedge clk);
                pulses += int'(done | timeout);
            end
            chk("ab_no_pulse", pulses, 0);
        end

        // abort during discharge keeps the old count
        @(negedge clk);
        start  = 1'b1;
        lo_scr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abd_busy", int'(busy), 0);
        chk("abd_count", int'(count), 30);

        // async reset at charge cycle 20
        @(negedge clk);
        start  = 1'b1;
        lo_scr = 1'b1;
        hi_scr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 20) @(negedge clk);
        chk("rm_pre_count", int'(count), 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_busy", int'(busy), 0);
        chk("rm_count", int'(count), 0);
        chk_real("rm_vin", vin_drv, 0.0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        // RC model: nominal and pre-charged cap
        run_rc(0.0, "rc_nom");
        run_rc(1.0, "rc_pre");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
